// File: rtl/core_obi_arbiter_pkg.sv
// Shared widths and helpers for the multicore OBI data-port arbiter.
package core_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int WORD_W = ADDR_W - 2;

    typedef logic [WORD_W-1:0] word_addr_t;

    // Index width that never collapses to zero bits, so a single core still has a legal index.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/core_obi_arbiter_if.sv
// Bundle of every core-side and memory-side signal the arbiter touches.
interface core_obi_arbiter_if
    import core_arb_pkg::*;
#(
    parameter int NUM_CORES = 2
);
    // req/gnt: a requester holds req and its fields stable until gnt; the transfer happens in
    // the cycle both are high. rvalid is a single-cycle response with no back-pressure.
    logic [NUM_CORES-1:0]             core_req_i;
    logic [NUM_CORES-1:0]             core_gnt_o;
    logic [NUM_CORES-1:0][ADDR_W-1:0] core_addr_i;
    logic [NUM_CORES-1:0][BE_W-1:0]   core_be_i;
    logic [NUM_CORES-1:0]             core_we_i;
    logic [NUM_CORES-1:0][DATA_W-1:0] core_wdata_i;
    logic [NUM_CORES-1:0]             core_lr_sc_i;
    logic [NUM_CORES-1:0]             core_rvalid_o;
    logic [NUM_CORES-1:0][DATA_W-1:0] core_rdata_o;
    logic [NUM_CORES-1:0]             core_err_o;
    logic [NUM_CORES-1:0]             core_exokay_o;

    logic                             mem_req_o;
    logic                             mem_gnt_i;
    logic [ADDR_W-1:0]                mem_addr_o;
    logic [BE_W-1:0]                  mem_be_o;
    logic                             mem_we_o;
    logic [DATA_W-1:0]                mem_wdata_o;
    logic                             mem_rvalid_i;
    logic [DATA_W-1:0]                mem_rdata_i;
    logic                             mem_err_i;

    // The arbiter serves the cores and fronts the memory.
    modport slave (
        input  core_req_i, core_addr_i, core_be_i, core_we_i, core_wdata_i, core_lr_sc_i,
        output core_gnt_o, core_rvalid_o, core_rdata_o, core_err_o, core_exokay_o,
        output mem_req_o, mem_addr_o, mem_be_o, mem_we_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
    );

    // The environment: the cores plus the shared data memory.
    modport master (
        output core_req_i, core_addr_i, core_be_i, core_we_i, core_wdata_i, core_lr_sc_i,
        input  core_gnt_o, core_rvalid_o, core_rdata_o, core_err_o, core_exokay_o,
        input  mem_req_o, mem_addr_o, mem_be_o, mem_we_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
    );

endinterface

// File: rtl/core_obi_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module rr_arbiter
    import core_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    int slot;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        slot    = 0;
        for (int i = 0; i < N; i++) begin
            slot = int'(ptr_i) + i;
            if (slot >= N) begin
                slot = slot - N;
            end
            if (!valid_o && req_i[slot]) begin
                valid_o     = 1'b1;
                gnt_o[slot] = 1'b1;
                idx_o       = IW'(slot);
            end
        end
    end

endmodule

// File: rtl/core_obi_arbiter.sv
// Merges NUM_CORES OBI data ports onto one memory port with round-robin arbitration,
// in-order response routing and per-core LR/SC reservations; failed SCs complete locally.
module core_obi_arbiter
    import core_arb_pkg::*;
#(
    parameter int NUM_CORES       = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input logic                clk_i,
    input logic                reset_i,
    core_obi_arbiter_if.slave  bus
);

    localparam int ID_W  = clog2_min1(NUM_CORES);
    localparam int PTR_W = clog2_min1(MAX_OUTSTANDING);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            is_local;
        logic            exok;
    } arb_entry_t;

    logic [ID_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    arb_entry_t                  fifo_q [MAX_OUTSTANDING];
    arb_entry_t                  fifo_d [MAX_OUTSTANDING];
    logic [NUM_CORES-1:0]        resv_v_q, resv_v_d;
    word_addr_t [NUM_CORES-1:0]  resv_a_q, resv_a_d;

    logic [NUM_CORES-1:0] req_act;
    logic [NUM_CORES-1:0] win_onehot;
    logic [ID_W-1:0]      win_idx;
    logic                 win_valid;

    logic [ADDR_W-1:0]    w_addr;
    logic [BE_W-1:0]      w_be;
    logic [DATA_W-1:0]    w_wdata;
    logic                 w_we;
    logic                 w_lr_sc;
    logic                 w_resv_hit;
    logic                 fail_sc;

    logic                 fifo_empty;
    logic                 fifo_full;
    arb_entry_t           head;
    logic                 head_valid;
    logic                 mem_resp;
    logic                 pop;
    logic                 stall;
    logic                 mem_req;
    logic                 accept;
    arb_entry_t           push_entry;

    logic [NUM_CORES-1:0]             rsp_rvalid;
    logic [NUM_CORES-1:0]             rsp_err;
    logic [NUM_CORES-1:0]             rsp_exokay;
    logic [NUM_CORES-1:0][DATA_W-1:0] rsp_rdata;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Reset masks requests so nothing is granted or forwarded while the system is held.
    assign req_act = bus.core_req_i & {NUM_CORES{!reset_i}};

    rr_arbiter #(
        .N  (NUM_CORES),
        .IW (ID_W)
    ) u_rr (
        .req_i   (req_act),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (win_onehot),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    assign w_addr  = bus.core_addr_i[win_idx];
    assign w_be    = bus.core_be_i[win_idx];
    assign w_wdata = bus.core_wdata_i[win_idx];
    assign w_we    = bus.core_we_i[win_idx];
    assign w_lr_sc = bus.core_lr_sc_i[win_idx];

    assign w_resv_hit = resv_v_q[win_idx] && (resv_a_q[win_idx] == w_addr[ADDR_W-1:2]);
    assign fail_sc    = win_valid && w_lr_sc && w_we && !w_resv_hit;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign head       = fifo_q[rd_ptr_q];
    assign head_valid = !fifo_empty && !reset_i;
    assign mem_resp   = head_valid && !head.is_local && bus.mem_rvalid_i;
    assign pop        = head_valid && (head.is_local || bus.mem_rvalid_i);

    // A full FIFO still accepts when its head retires in the same cycle.
    assign stall   = fifo_full && !pop;
    assign mem_req = win_valid && !stall && !fail_sc;
    assign accept  = win_valid && !stall && (fail_sc || bus.mem_gnt_i);

    assign push_entry = '{id: win_idx, is_local: fail_sc, exok: w_lr_sc && !fail_sc};

    assign bus.core_gnt_o  = accept ? win_onehot : '0;
    assign bus.mem_req_o   = mem_req;
    assign bus.mem_addr_o  = mem_req ? w_addr  : '0;
    assign bus.mem_be_o    = mem_req ? w_be    : '0;
    assign bus.mem_we_o    = mem_req && w_we;
    assign bus.mem_wdata_o = mem_req ? w_wdata : '0;

    always_comb begin
        rsp_rvalid = '0;
        rsp_err    = '0;
        rsp_exokay = '0;
        rsp_rdata  = '0;
        if (pop) begin
            rsp_rvalid[head.id] = 1'b1;
            rsp_exokay[head.id] = head.exok;
            rsp_err[head.id]    = mem_resp && bus.mem_err_i;
        end
        if (mem_resp) begin
            for (int c = 0; c < NUM_CORES; c++) begin
                rsp_rdata[c] = bus.mem_rdata_i;
            end
        end
    end

    assign bus.core_rvalid_o = rsp_rvalid;
    assign bus.core_err_o    = rsp_err;
    assign bus.core_exokay_o = rsp_exokay;
    assign bus.core_rdata_o  = rsp_rdata;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        fifo_d   = fifo_q;
        resv_v_d = resv_v_q;
        resv_a_d = resv_a_q;

        if (accept) begin
            rr_ptr_d         = (win_idx == ID_W'(NUM_CORES - 1)) ? '0 : win_idx + 1'b1;
            fifo_d[wr_ptr_q] = push_entry;
            wr_ptr_d         = ptr_inc(wr_ptr_q);

            // A store that reaches memory breaks every other core's reservation on that word.
            if (w_we && !fail_sc) begin
                for (int k = 0; k < NUM_CORES; k++) begin
                    if ((ID_W'(k) != win_idx) && (resv_a_q[k] == w_addr[ADDR_W-1:2])) begin
                        resv_v_d[k] = 1'b0;
                    end
                end
            end
            if (w_lr_sc && w_we) begin
                resv_v_d[win_idx] = 1'b0;
            end
            if (w_lr_sc && !w_we) begin
                resv_v_d[win_idx] = 1'b1;
                resv_a_d[win_idx] = w_addr[ADDR_W-1:2];
            end
        end

        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            resv_v_q <= '0;
            resv_a_q <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            resv_v_q <= resv_v_d;
            resv_a_q <= resv_a_d;
            fifo_q   <= fifo_d;
        end
    end

    // Memory responses are strictly in order and only ever answer forwarded requests.
    assert property (@(posedge clk_i) disable iff (reset_i)
        !(bus.mem_rvalid_i && fifo_empty));
    assert property (@(posedge clk_i) disable iff (reset_i)
        !(bus.mem_rvalid_i && !fifo_empty && head.is_local));

endmodule

// File: tb/tb_core_obi_arbiter.sv
// Directed, table-driven bench for core_obi_arbiter with two cores and a two-deep response FIFO.
module tb_core_obi_arbiter;

    typedef struct {
        string       name;
        logic [1:0]  req;
        logic [1:0]  lr;
        logic [1:0]  we;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        mgnt;
        logic        mrv;
        logic [31:0] mrd;
        logic        merr;
        logic [1:0]  e_gnt;
        logic        e_mreq;
        int          e_win;
        logic [1:0]  e_rv;
        logic [31:0] e_rd;
        logic [1:0]  e_exok;
        logic [1:0]  e_err;
    } vec_t;

    localparam logic [3:0]  BE_C [2] = '{4'hF, 4'h3};
    localparam logic [31:0] WD_C [2] = '{32'hC0DE_0000, 32'hC0DE_0001};

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    core_obi_arbiter_if #(.NUM_CORES(2)) bus ();

    core_obi_arbiter #(
        .NUM_CORES       (2),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    function automatic vec_t mk(input string n, input logic [1:0] req, input logic [1:0] lr,
                                input logic [1:0] we, input logic [31:0] a0, input logic [31:0] a1,
                                input logic mgnt, input logic mrv, input logic [31:0] mrd,
                                input logic merr, input logic [1:0] e_gnt, input logic e_mreq,
                                input int e_win, input logic [1:0] e_rv, input logic [31:0] e_rd,
                                input logic [1:0] e_exok, input logic [1:0] e_err);
        vec_t v;
        v.name = n;     v.req = req;   v.lr = lr;     v.we = we;
        v.a0 = a0;      v.a1 = a1;     v.mgnt = mgnt; v.mrv = mrv;
        v.mrd = mrd;    v.merr = merr; v.e_gnt = e_gnt;
        v.e_mreq = e_mreq; v.e_win = e_win; v.e_rv = e_rv;
        v.e_rd = e_rd;  v.e_exok = e_exok; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.core_req_i     = v.req;
        bus.core_lr_sc_i   = v.lr;
        bus.core_we_i      = v.we;
        bus.core_addr_i[0] = v.a0;
        bus.core_addr_i[1] = v.a1;
        bus.mem_gnt_i      = v.mgnt;
        bus.mem_rvalid_i   = v.mrv;
        bus.mem_rdata_i    = v.mrd;
        bus.mem_err_i      = v.merr;
    endtask

    // Entered just after a rising edge; checks on the falling edge; leaves just after the next rising edge.
    task automatic run_vec(input vec_t v);
        logic [79:0] exp_req;
        logic [79:0] exp_rsp;
        logic [79:0] got_req;
        logic [79:0] got_rsp;
        int          w;
        w = (v.e_win == 1) ? 1 : 0;
        drive(v);
        exp_req = {8'h0, v.e_gnt, v.e_mreq, v.e_mreq & v.we[w],
                   v.e_mreq ? (w == 1 ? v.a1 : v.a0) : 32'h0,
                   v.e_mreq ? BE_C[w] : 4'h0,
                   v.e_mreq ? WD_C[w] : 32'h0};
        exp_rsp = {10'h0, v.e_rv, v.e_rd, v.e_rd, v.e_exok, v.e_err};
        @(negedge clk);
        got_req = {8'h0, bus.core_gnt_o, bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o,
                   bus.mem_be_o, bus.mem_wdata_o};
        got_rsp = {10'h0, bus.core_rvalid_o, bus.core_rdata_o[0], bus.core_rdata_o[1],
                   bus.core_exokay_o, bus.core_err_o};
        check({v.name, ".req"}, got_req, exp_req);
        check({v.name, ".rsp"}, got_rsp, exp_rsp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.core_be_i[0]    = BE_C[0];
        bus.core_be_i[1]    = BE_C[1];
        bus.core_wdata_i[0] = WD_C[0];
        bus.core_wdata_i[1] = WD_C[1];
        drive(mk("init", 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00));

        //                name          req    lr     we     a0      a1      gnt rv rdata          er  e_gnt  mreq win e_rv   e_rd           exok   err
        vecs.push_back(mk("idle",       2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  0, 0, 32'h0,          0, 2'b00, 0, 0, 2'b00, 32'h0,          2'b00, 2'b00));
        vecs.push_back(mk("rr0",        2'b11, 2'b00, 2'b00, 32'h10, 32'h20, 1, 0, 32'h0,          0, 2'b01, 1, 0, 2'b00, 32'h0,          2'b00, 2'b00));
        vecs.push_back(mk("rr1",        2'b11, 2'b00, 2'b00, 32'h10, 32'h20, 1, 1, 32'hAAAA_0001,  0, 2'b10, 1, 1, 2'b01, 32'hAAAA_0001,  2'b00, 2'b00));
        vecs.push_back(mk("rr2",        2'b11, 2'b00, 2'b00, 32'h10, 32'h20, 1, 1, 32'hBBBB_0002,  1, 2'b01, 1, 0, 2'b10, 32'hBBBB_0002,  2'b00, 2'b10));
        vecs.push_back(mk("rr_drain",   2'b00, 2'b00, 2'b00, 32'h10, 32'h20, 0, 1, 32'hCCCC_0003,  0, 2'b00, 0, 0, 2'b01, 32'hCCCC_0003,  2'b00, 2'b00));
        vecs.push_back(mk("bp_a1",      2'b10, 2'b00, 2'b00, 32'h0,  32'h30, 1, 0, 32'h0,          0, 2'b10, 1, 1, 2'b00, 32'h0,          2'b00, 2'b00));
        vecs.push_back(mk("bp_a2",      2'b01, 2'b00, 2'b00, 32'h40, 32'h30, 1, 0, 32'h0,          0, 2'b01, 1, 0, 2'b00, 32'h0,          2'b00, 2'b00));
        vecs.push_back(mk("bp_full0",   2'b10, 2'b00, 2'b00, 32'h40, 32'h50, 1, 0, 32'h0,          0, 2'b00, 0, 0, 2'b00, 32'h0,          2'b00, 2'b00));
        vecs.push_back(mk("bp_full1",   2'b10, 2'b00, 2'b00, 32'h40, 32'h50, 1, 0, 32'h0,          0, 2'b00, 0, 0, 2'b00, 32'h0,          2'b00, 2'b00));
        vecs.push_back(mk("bp_pop",     2'b10, 2'b00, 2'b00, 32'h40, 32'h50, 1, 1, 32'h11,         0, 2'b10, 1, 1, 2'b10, 32'h11,         2'b00, 2'b00));
        vecs.push_back(mk("bp_d1",      2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  0, 1, 32'h22,         0, 2'b00, 0, 0, 2'b01, 32'h22,         2'b00, 2'b00));
        vecs.push_back(mk("bp_d2",      2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  0, 1, 32'h33,         0, 2'b00, 0, 0, 2'b10, 32'h33,         2'b00, 2'b00));
        vecs.push_back(mk("no_mgnt",    2'b01, 2'b00, 2'b00, 32'h60, 32'h0,  0, 0, 32'h0,          0, 2'b00, 1, 0, 2'b00, 32'h0,          2'b00, 2'b00));
        vecs.push_back(mk("lr",         2'b01, 2'b01, 2'b00, 32'h100,32'h0,  1, 0, 32'h0,          0, 2'b01, 1, 0, 2'b00, 32'h0,          2'b00, 2'b00));
        vecs.push_back(mk("lr_rsp",     2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  0, 1, 32'h5,          0, 2'b00, 0, 0, 2'b01, 32'h5,          2'b01, 2'b00));
        vecs.push_back(mk("sc_ok",      2'b01, 2'b01, 2'b01, 32'h100,32'h0,  1, 0, 32'h0,          0, 2'b01, 1, 0, 2'b00, 32'h0,          2'b00, 2'b00));
        vecs.push_back(mk("sc_ok_rsp",  2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  0, 1, 32'h0,          0, 2'b00, 0, 0, 2'b01, 32'h0,          2'b01, 2'b00));
        vecs.push_back(mk("lr2",        2'b01, 2'b01, 2'b00, 32'h100,32'h0,  1, 0, 32'h0,          0, 2'b01, 1, 0, 2'b00, 32'h0,          2'b00, 2'b00));
        vecs.push_back(mk("sw_c1",      2'b10, 2'b00, 2'b10, 32'h100,32'h102,1, 1, 32'h7,          0, 2'b10, 1, 1, 2'b01, 32'h7,          2'b01, 2'b00));
        vecs.push_back(mk("sc_bad",     2'b01, 2'b01, 2'b01, 32'h100,32'h0,  1, 1, 32'h0,          0, 2'b01, 0, 0, 2'b10, 32'h0,          2'b00, 2'b00));
        vecs.push_back(mk("sc_bad_rsp", 2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  0, 0, 32'h0,          0, 2'b00, 0, 0, 2'b01, 32'h0,          2'b00, 2'b00));
        vecs.push_back(mk("ord_rd",     2'b01, 2'b00, 2'b00, 32'h200,32'h0,  1, 0, 32'h0,          0, 2'b01, 1, 0, 2'b00, 32'h0,          2'b00, 2'b00));
        vecs.push_back(mk("ord_sc",     2'b01, 2'b01, 2'b01, 32'h200,32'h0,  1, 0, 32'h0,          0, 2'b01, 0, 0, 2'b00, 32'h0,          2'b00, 2'b00));
        vecs.push_back(mk("ord_wait",   2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  0, 0, 32'h0,          0, 2'b00, 0, 0, 2'b00, 32'h0,          2'b00, 2'b00));
        vecs.push_back(mk("ord_rd_rsp", 2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  0, 1, 32'h99,         0, 2'b00, 0, 0, 2'b01, 32'h99,         2'b00, 2'b00));
        vecs.push_back(mk("ord_sc_rsp", 2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  0, 0, 32'h0,          0, 2'b00, 0, 0, 2'b01, 32'h0,          2'b00, 2'b00));
        vecs.push_back(mk("lr_c1",      2'b10, 2'b10, 2'b00, 32'h0,  32'h300,1, 0, 32'h0,          0, 2'b10, 1, 1, 2'b00, 32'h0,          2'b00, 2'b00));
        vecs.push_back(mk("sw_c0_oth",  2'b01, 2'b00, 2'b01, 32'h304,32'h300,1, 1, 32'h42,         0, 2'b01, 1, 0, 2'b10, 32'h42,         2'b10, 2'b00));
        vecs.push_back(mk("sc_c1",      2'b10, 2'b10, 2'b10, 32'h0,  32'h300,1, 1, 32'h0,          0, 2'b10, 1, 1, 2'b01, 32'h0,          2'b00, 2'b00));
        vecs.push_back(mk("sc_c1_rsp",  2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  0, 1, 32'h0,          0, 2'b00, 0, 0, 2'b10, 32'h0,          2'b10, 2'b00));

        // Two reset cycles with every request low; outputs must read zero during the second.
        @(posedge clk);
        #1;
        run_vec(mk("reset", 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00));
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
        end

        // Reset mid-transfer: a queued local SC must be dropped and the pointer return to core 0.
        run_vec(mk("mr_sc",    2'b01, 2'b01, 2'b01, 32'h500, 32'h0,  1, 0, 32'h0,  0, 2'b01, 0, 0, 2'b00, 32'h0,  2'b00, 2'b00));
        reset = 1'b1;
        run_vec(mk("mr_rst",   2'b11, 2'b00, 2'b00, 32'h10,  32'h20, 1, 0, 32'h0,  0, 2'b00, 0, 0, 2'b00, 32'h0,  2'b00, 2'b00));
        reset = 1'b0;
        run_vec(mk("mr_flush", 2'b00, 2'b00, 2'b00, 32'h0,   32'h0,  0, 0, 32'h0,  0, 2'b00, 0, 0, 2'b00, 32'h0,  2'b00, 2'b00));
        run_vec(mk("mr_rr",    2'b11, 2'b00, 2'b00, 32'h10,  32'h20, 1, 0, 32'h0,  0, 2'b01, 1, 0, 2'b00, 32'h0,  2'b00, 2'b00));
        run_vec(mk("mr_drain", 2'b00, 2'b00, 2'b00, 32'h0,   32'h0,  0, 1, 32'h77, 0, 2'b00, 0, 0, 2'b01, 32'h77, 2'b00, 2'b00));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
